// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock/alarm setting controller.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        EDIT_HR,
        EDIT_MIN,
        COMMIT
    } state_t;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [1:0] hr_tens_t;

    typedef struct packed {
        hr_tens_t   h1;
        bcd_digit_t h0;
        bcd_digit_t m1;
        bcd_digit_t m0;
    } hhmm_t;

    // BCD-packed upper bounds: 8'h23 reads as 23, 8'h59 as 59.
    localparam logic [7:0] MAX_HR  = 8'h23;
    localparam logic [7:0] MAX_MIN = 8'h59;

    // Out-of-range or non-BCD fields from the core saturate to the field maximum.
    function automatic hhmm_t clamp_time(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.h0 > 4'd9 || {2'b00, t.h1, t.h0} > MAX_HR) begin
            r.h1 = MAX_HR[5:4];
            r.h0 = MAX_HR[3:0];
        end
        if (t.m0 > 4'd9 || {t.m1, t.m0} > MAX_MIN) begin
            r.m1 = MAX_MIN[7:4];
            r.m0 = MAX_MIN[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational +1/-1 on a two-digit BCD pair, wrapping between 00 and MAX_VAL.
module bcd_step
    import clock_ctrl_pkg::*;
#(
    parameter int         TENS_W  = 4,
    parameter logic [7:0] MAX_VAL = MAX_MIN
) (
    input  logic              inc,
    input  logic              dec,
    input  logic [TENS_W-1:0] tens_in,
    input  bcd_digit_t        ones_in,
    output logic [TENS_W-1:0] tens_out,
    output bcd_digit_t        ones_out
);

    localparam logic [TENS_W-1:0] MAX_T = MAX_VAL[TENS_W+3:4];
    localparam bcd_digit_t        MAX_O = MAX_VAL[3:0];
    localparam logic [TENS_W-1:0] T_ONE = 1;

    always_comb begin
        tens_out = tens_in;
        ones_out = ones_in;
        if (inc && !dec) begin
            if (tens_in == MAX_T && ones_in == MAX_O) begin
                tens_out = '0;
                ones_out = '0;
            end else if (ones_in >= 4'd9) begin
                tens_out = tens_in + T_ONE;
                ones_out = '0;
            end else begin
                ones_out = ones_in + 4'd1;
            end
        end else if (dec && !inc) begin
            if (tens_in == '0 && ones_in == '0) begin
                tens_out = MAX_T;
                ones_out = MAX_O;
            end else if (ones_in == '0) begin
                tens_out = tens_in - T_ONE;
                ones_out = 4'd9;
            end else begin
                ones_out = ones_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven HH:MM setting sequencer for clock or alarm time, with one-cycle load pulses.
// Optional AUTO_REPEAT_EN adds hold-to-repeat on inc/dec while editing a field.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 300,
    parameter int BLINK_DIV     = 5
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_RATE   = 2
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       target_alarm,
    output logic       edit_active,
    output logic       blink_hr,
    output logic       blink_min
);

    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    state_t            state, state_nx;
    logic [3:0]        btn_q, btn_qq, edges;
    logic              mode_e, set_e, inc_e, dec_e;
    logic              timeout, ok_step, load, toggle;
    logic              step_inc, step_dec;
    logic              rpt_inc, rpt_dec, rpt_fire;
    logic              target_q;
    hhmm_t             edit_q, shadow_q, cur_t;
    hr_tens_t          hr_t_nx;
    bcd_digit_t        hr_o_nx, mn_t_nx, mn_o_nx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic              blk_ph;

    // Buttons are sampled once; edges come from the registered level only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q  <= '0;
            btn_qq <= '0;
        end else begin
            btn_q  <= {btn_mode, btn_set, btn_inc, btn_dec};
            btn_qq <= btn_q;
        end
    end

    assign edges  = btn_q & ~btn_qq;
    assign mode_e = edges[3];
    assign set_e  = edges[2];
    assign inc_e  = edges[1];
    assign dec_e  = edges[0];
    assign cur_t  = {cur_h1, cur_h0, cur_m1, cur_m0};

    assign timeout = (state != IDLE) && (state != COMMIT) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));

    // Arbitration: mode > timeout > set > inc/dec.
    assign ok_step  = !mode_e && !timeout && !set_e;
    assign step_inc = ok_step && ((inc_e && !dec_e) || rpt_inc);
    assign step_dec = ok_step && ((dec_e && !inc_e) || rpt_dec);
    assign toggle   = (state == SEL) && ok_step && (inc_e ^ dec_e);
    assign load     = (state == SEL) && !mode_e && !timeout && set_e;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (mode_e) state_nx = SEL;
            SEL:      if (mode_e || timeout) state_nx = IDLE;
                      else if (set_e) state_nx = EDIT_HR;
            EDIT_HR:  if (mode_e || timeout) state_nx = IDLE;
                      else if (set_e) state_nx = EDIT_MIN;
            EDIT_MIN: if (mode_e || timeout) state_nx = IDLE;
                      else if (set_e) state_nx = COMMIT;
            COMMIT:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       target_q <= 1'b0;
        else if (state == IDLE && mode_e) target_q <= 1'b0;
        else if (toggle)                  target_q <= ~target_q;
    end

    bcd_step #(.TENS_W(2), .MAX_VAL(MAX_HR)) u_hr_step (
        .inc      (step_inc && state == EDIT_HR),
        .dec      (step_dec && state == EDIT_HR),
        .tens_in  (edit_q.h1),
        .ones_in  (edit_q.h0),
        .tens_out (hr_t_nx),
        .ones_out (hr_o_nx)
    );

    bcd_step #(.TENS_W(4), .MAX_VAL(MAX_MIN)) u_min_step (
        .inc      (step_inc && state == EDIT_MIN),
        .dec      (step_dec && state == EDIT_MIN),
        .tens_in  (edit_q.m1),
        .ones_in  (edit_q.m0),
        .tens_out (mn_t_nx),
        .ones_out (mn_o_nx)
    );

    // Edit register keeps its value in IDLE so the bus is stable across the load pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_q <= '0;
        end else if (load) begin
            edit_q <= target_q ? shadow_q : clamp_time(cur_t);
        end else if (state == EDIT_HR) begin
            edit_q.h1 <= hr_t_nx;
            edit_q.h0 <= hr_o_nx;
        end else if (state == EDIT_MIN) begin
            edit_q.m1 <= mn_t_nx;
            edit_q.m0 <= mn_o_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         shadow_q <= '0;
        else if (state == COMMIT && target_q) shadow_q <= edit_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_cnt <= '0;
        else if (state_nx != state || |edges || rpt_fire)
            tmo_cnt <= '0;
        else if (state != IDLE)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt <= '0;
            blk_ph  <= 1'b0;
        end else if (state_nx != state) begin
            blk_cnt <= '0;
            blk_ph  <= 1'b0;
        end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt <= '0;
            blk_ph  <= ~blk_ph;
        end else begin
            blk_cnt <= blk_cnt + BLK_W'(1);
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_hold;

    assign rpt_hold = (state == EDIT_HR || state == EDIT_MIN) && (btn_q[1] ^ btn_q[0]);
    assign rpt_fire = rpt_hold && (rpt_cnt == RPT_W'(REPEAT_DELAY));
    assign rpt_inc  = rpt_fire && btn_q[1];
    assign rpt_dec  = rpt_fire && btn_q[0];

    // After the first repeat, rewinding by REPEAT_RATE-1 yields one step per REPEAT_RATE cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rpt_cnt <= '0;
        else if (!rpt_hold || state_nx != state)
            rpt_cnt <= '0;
        else if (rpt_fire)
            rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
        else
            rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
`else
    assign rpt_fire = 1'b0;
    assign rpt_inc  = 1'b0;
    assign rpt_dec  = 1'b0;
`endif

    assign H_in1        = edit_q.h1;
    assign H_in0        = edit_q.h0;
    assign M_in1        = edit_q.m1;
    assign M_in0        = edit_q.m0;
    assign LD_time      = (state == COMMIT) && !target_q;
    assign LD_alarm     = (state == COMMIT) && target_q;
    assign target_alarm = target_q;
    assign edit_active  = (state != IDLE);
    assign blink_hr     = (state == EDIT_HR) && blk_ph;
    assign blink_min    = (state == EDIT_MIN) && blk_ph;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: edit sequences, wraps, aborts, timeout, reset in commit.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_set = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [1:0] cur_h1 = '0;
    logic [3:0] cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, target_alarm, edit_active, blink_hr, blink_min;

    int errs = 0, checks = 0;
    int n_ldt = 0, n_lda = 0;
    int ldt0, lda0, tg, mn_on;
    logic prev_b;

    clock_set_ctrl dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .target_alarm(target_alarm),
        .edit_active(edit_active), .blink_hr(blink_hr), .blink_min(blink_min)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (LD_time)  n_ldt++;
        if (LD_alarm) n_lda++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] bus();
        return {16'h0, 2'b00, H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic press(input logic m, input logic s, input logic i, input logic d);
        @(negedge clk);
        btn_mode = m; btn_set = s; btn_inc = i; btn_dec = d;
        @(negedge clk);
        @(negedge clk);
        btn_mode = 0; btn_set = 0; btn_inc = 0; btn_dec = 0;
        @(negedge clk);
    endtask

    task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0,
                           input logic [3:0] m1, input logic [3:0] m0);
        cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bus", bus(), 32'h0000);
        chk("rst_active", {31'b0, edit_active}, 0);
        chk("rst_ld", {30'b0, LD_time, LD_alarm}, 0);
        chk("rst_misc", {29'b0, target_alarm, blink_hr, blink_min}, 0);
        reset = 1'b1;

        // Time edit 11:26 -> 13:27
        set_cur(2'd1, 4'd1, 4'd2, 4'd6);
        press(1, 0, 0, 0);
        chk("sel_active", {31'b0, edit_active}, 1);
        chk("sel_target", {31'b0, target_alarm}, 0);
        press(0, 1, 0, 0);
        chk("preload_time", bus(), 32'h1126);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        chk("hr_inc2", bus(), 32'h1326);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        chk("min_inc", bus(), 32'h1327);
        ldt0 = n_ldt; lda0 = n_lda;
        press(0, 1, 0, 0);
        chk("ld_time_pulse", n_ldt - ldt0, 1);
        chk("no_ld_alarm", n_lda - lda0, 0);
        chk("bus_after_commit", bus(), 32'h1327);
        chk("idle_after_commit", {31'b0, edit_active}, 0);

        // Alarm edit with wraps from 00
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        chk("target_alarm", {31'b0, target_alarm}, 1);
        press(0, 1, 0, 0);
        chk("preload_shadow0", bus(), 32'h0000);
        press(0, 0, 0, 1);
        chk("hr_dec_wrap", bus(), 32'h2300);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        chk("min_dec_wrap", bus(), 32'h2359);
        ldt0 = n_ldt; lda0 = n_lda;
        press(0, 1, 0, 0);
        chk("ld_alarm_pulse", n_lda - lda0, 1);
        chk("no_ld_time", n_ldt - ldt0, 0);
        chk("alarm_bus", bus(), 32'h2359);
        press(1, 0, 0, 0); press(0, 0, 1, 0); press(0, 1, 0, 0);
        chk("preload_shadow", bus(), 32'h2359);

        // Abort in EDIT_MIN leaves shadow intact
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        chk("min_inc_wrap", bus(), 32'h2300);
        ldt0 = n_ldt; lda0 = n_lda;
        press(1, 0, 0, 0);
        chk("abort_idle", {31'b0, edit_active}, 0);
        chk("abort_no_ld", (n_ldt - ldt0) + (n_lda - lda0), 0);
        press(1, 0, 0, 0); press(0, 0, 1, 0); press(0, 1, 0, 0);
        chk("shadow_kept", bus(), 32'h2359);
        press(1, 0, 0, 0);

        // Hour carries and blink
        set_cur(2'd0, 4'd9, 4'd5, 4'd9);
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        chk("preload_0959", bus(), 32'h0959);
        tg = 0; mn_on = 0; prev_b = blink_hr;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (blink_hr != prev_b) tg++;
            if (blink_min) mn_on++;
            prev_b = blink_hr;
        end
        chk("blink_hr_toggles", tg, 4);
        chk("blink_min_off", mn_on, 0);
        press(0, 0, 1, 0);
        chk("hr_09_10", bus(), 32'h1059);
        repeat (9) press(0, 0, 1, 0);
        chk("hr_to_19", bus(), 32'h1959);
        press(0, 0, 1, 0);
        chk("hr_19_20", bus(), 32'h2059);
        repeat (10) press(0, 0, 0, 1);
        chk("hr_dec_to_10", bus(), 32'h1059);
        press(0, 0, 0, 1);
        chk("hr_10_09", bus(), 32'h0959);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        chk("min_59_00", bus(), 32'h0900);
        press(1, 0, 0, 0);

        // Clamp out-of-range preload, then timeout behaviour
        set_cur(2'd2, 4'd5, 4'd6, 4'd1);
        ldt0 = n_ldt; lda0 = n_lda;
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        chk("clamp", bus(), 32'h2359);
        repeat (290) @(negedge clk);
        chk("tmo_not_yet", {31'b0, edit_active}, 1);
        press(0, 0, 1, 0);
        repeat (200) @(negedge clk);
        chk("tmo_restart", {31'b0, edit_active}, 1);
        chk("tmo_inc_value", bus(), 32'h0059);
        repeat (150) @(negedge clk);
        chk("tmo_abort", {31'b0, edit_active}, 0);
        chk("tmo_no_ld", (n_ldt - ldt0) + (n_lda - lda0), 0);

        // Simultaneous buttons
        set_cur(2'd1, 4'd1, 4'd2, 4'd6);
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        press(0, 0, 1, 1);
        chk("inc_dec_same", bus(), 32'h1126);
        press(0, 1, 1, 0);
        chk("set_inc_value", bus(), 32'h1126);
        press(0, 0, 1, 0);
        chk("set_inc_advanced", bus(), 32'h1127);

        // Reset during COMMIT
        @(negedge clk); btn_set = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("commit_seen", {31'b0, LD_time}, 1);
        reset = 1'b0;
        #1;
        chk("rst_commit_ld", {31'b0, LD_time}, 0);
        chk("rst_commit_bus", bus(), 32'h0000);
        chk("rst_commit_idle", {31'b0, edit_active}, 0);
        @(negedge clk); btn_set = 1'b0; reset = 1'b1;
        @(negedge clk);

        // Holding inc for 20 cycles in EDIT_MIN
        set_cur(2'd1, 4'd1, 4'd0, 4'd0);
        press(1, 0, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
        chk("hold_start", bus(), 32'h1100);
        @(negedge clk); btn_inc = 1'b1;
        repeat (20) @(negedge clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
`ifdef AUTO_REPEAT_EN
        chk("hold_repeat", bus(), 32'h1106);
`else
        chk("hold_single", bus(), 32'h1101);
`endif
        press(1, 0, 0, 0);
        chk("final_idle", {31'b0, edit_active}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
